// File: rtl/demux_n_reg_if.sv
// Handshake bundle for demux_n_reg: one producer stream in, two consumer streams out.
interface demux_n_reg_if #(
    parameter int N = 32
);
    logic         in_valid;
    logic         in_ready;
    logic         in_sel;
    logic [N-1:0] in_data;
    logic         a_valid;
    logic         a_ready;
    logic [N-1:0] a_data;
    logic         b_valid;
    logic         b_ready;
    logic [N-1:0] b_data;

    modport master (
        output in_valid, in_sel, in_data, a_ready, b_ready,
        input  in_ready, a_valid, a_data, b_valid, b_data
    );

    modport slave (
        input  in_valid, in_sel, in_data, a_ready, b_ready,
        output in_ready, a_valid, a_data, b_valid, b_data
    );
endinterface

// File: rtl/demux_n_reg.sv
// Registered 1-to-2 word demultiplexer with a one-entry holding slot per output port,
// so back-pressure on one port never stalls traffic steered to the other.
module demux_n_reg #(
    parameter int N = 32
) (
    input  logic          clk,
    input  logic          rst,
    demux_n_reg_if.slave  bus
);
    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } slot_state_t;

    slot_state_t  r_a_state;
    slot_state_t  r_b_state;
    logic [N-1:0] r_a_data;
    logic [N-1:0] r_b_data;

    logic w_in_ready;
    logic w_in_xfer;
    logic w_a_load;
    logic w_b_load;

    // Ready for the addressed slot: empty, or draining this very cycle.
    always_comb begin
        w_in_ready = 1'b1;
        if (bus.in_sel == 1'b1) begin
            w_in_ready = (r_a_state == S_EMPTY) | bus.a_ready;
        end else begin
            w_in_ready = (r_b_state == S_EMPTY) | bus.b_ready;
        end
    end

    assign w_in_xfer = bus.in_valid & w_in_ready;
    assign w_a_load  = w_in_xfer & bus.in_sel;
    assign w_b_load  = w_in_xfer & ~bus.in_sel;

    // Slot A: load on steered input (including refill while draining), empty on drain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_state <= S_EMPTY;
            r_a_data  <= {N{1'b0}};
        end else begin
            case (r_a_state)
                S_EMPTY: begin
                    if (w_a_load) begin
                        r_a_state <= S_FULL;
                        r_a_data  <= bus.in_data;
                    end
                end
                S_FULL: begin
                    if (w_a_load) begin
                        r_a_data  <= bus.in_data;
                    end else if (bus.a_ready) begin
                        r_a_state <= S_EMPTY;
                    end
                end
                default: begin
                    r_a_state <= S_EMPTY;
                end
            endcase
        end
    end

    // Slot B: mirror of slot A for sel = 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_b_state <= S_EMPTY;
            r_b_data  <= {N{1'b0}};
        end else begin
            case (r_b_state)
                S_EMPTY: begin
                    if (w_b_load) begin
                        r_b_state <= S_FULL;
                        r_b_data  <= bus.in_data;
                    end
                end
                S_FULL: begin
                    if (w_b_load) begin
                        r_b_data  <= bus.in_data;
                    end else if (bus.b_ready) begin
                        r_b_state <= S_EMPTY;
                    end
                end
                default: begin
                    r_b_state <= S_EMPTY;
                end
            endcase
        end
    end

    assign bus.in_ready = w_in_ready;
    assign bus.a_valid  = (r_a_state == S_FULL);
    assign bus.a_data   = r_a_data;
    assign bus.b_valid  = (r_b_state == S_FULL);
    assign bus.b_data   = r_b_data;
endmodule
